// File: rtl/clk_divider_prog_if.sv
// Control/status bundle for clk_divider_prog: run request, divisor load strobe and the divided-clock outputs.
// tick_o exists only when CLK_DIV_PROG_TICK_EN is defined.
interface clk_divider_prog_if #(
  parameter int unsigned DIV_WIDTH = 8
);
  logic                 en_i;
  logic [DIV_WIDTH-1:0] div_i;
  logic                 div_load_i;
  logic                 div_ack_o;
  logic [DIV_WIDTH-1:0] cur_div_o;
  logic                 clk_o;
`ifdef CLK_DIV_PROG_TICK_EN
  logic                 tick_o;
`endif

  modport master (
    output en_i, div_i, div_load_i,
`ifdef CLK_DIV_PROG_TICK_EN
    input  tick_o,
`endif
    input  div_ack_o, cur_div_o, clk_o
  );

  modport slave (
    input  en_i, div_i, div_load_i,
`ifdef CLK_DIV_PROG_TICK_EN
    output tick_o,
`endif
    output div_ack_o, cur_div_o, clk_o
  );
endinterface

// File: rtl/clk_divider_prog.sv
// Runtime-programmable glitch-free integer clock divider (divisor 2..2^DIV_WIDTH-1), parks clk_o low when idle.
// Optional CLK_DIV_PROG_TICK_EN adds tick_o, a one-cycle pulse coincident with every clk_o rise.
//
// state    | meaning
// ST_IDLE  | clk_o parked low, cnt held at D-1, pending divisor applied immediately
// ST_RUN   | counting 0..D-1 continuously, clk_o = (cnt < D/2)
// ST_DRAIN | en_i dropped mid-period; finishing the period before parking
module clk_divider_prog #(
  parameter int unsigned DIV_WIDTH   = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk_i,
  input  logic             rst,
  clk_divider_prog_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [DIV_WIDTH-1:0] ONE   = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] TWO   = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] DEF_D = DIV_WIDTH'(DEFAULT_DIV);

  state_t               state_q, state_n;
  logic [DIV_WIDTH-1:0] d_q, d_n;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_n;
  logic [DIV_WIDTH-1:0] pend_q, pend_n;
  logic                 pend_vld_q, pend_vld_n;
  logic                 clk_q, clk_n;
  logic                 ack_q, ack_n;

  logic [DIV_WIDTH-1:0] div_clamped;
  logic [DIV_WIDTH-1:0] eff_div;
  logic                 eff_vld;
  logic                 at_end;
  logic                 apply;

  always_comb begin
    div_clamped = (bus.div_i < TWO) ? TWO : bus.div_i;
    eff_vld     = bus.div_load_i | pend_vld_q;
    eff_div     = bus.div_load_i ? div_clamped : pend_q;
    at_end      = (cnt_q == (d_q - ONE));
    apply       = at_end & eff_vld;

    d_n        = apply ? eff_div : d_q;
    pend_n     = bus.div_load_i ? div_clamped : pend_q;
    pend_vld_n = apply ? 1'b0 : eff_vld;
    ack_n      = apply;

    state_n = state_q;
    cnt_n   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.en_i) begin
          state_n = ST_RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = d_n - ONE;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (at_end) begin
          if (bus.en_i) begin
            state_n = ST_RUN;
            cnt_n   = '0;
          end else begin
            state_n = ST_IDLE;
            cnt_n   = d_n - ONE;
          end
        end else begin
          // Re-raising en_i mid-drain just keeps counting: no phase jump.
          state_n = bus.en_i ? ST_RUN : ST_DRAIN;
          cnt_n   = cnt_q + ONE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = d_q - ONE;
      end
    endcase

    // cnt_n is D-1 whenever idle, which is never below D/2, so clk_o parks low.
    clk_n = (cnt_n < (d_n >> 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      d_q        <= DEF_D;
      cnt_q      <= DEF_D - ONE;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      d_q        <= d_n;
      cnt_q      <= cnt_n;
      pend_q     <= pend_n;
      pend_vld_q <= pend_vld_n;
      clk_q      <= clk_n;
      ack_q      <= ack_n;
    end
  end

  assign bus.clk_o     = clk_q;
  assign bus.div_ack_o = ack_q;
  assign bus.cur_div_o = d_q;

`ifdef CLK_DIV_PROG_TICK_EN
  logic tick_q;

  always_ff @(posedge clk_i) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= clk_n & ~clk_q;
  end

  assign bus.tick_o = tick_q;
`endif

endmodule

// File: tb/tb_clk_divider_prog.sv
// Scoreboard bench for clk_divider_prog: stimulus pushes model predictions, a monitor pops and compares each cycle.
module tb_clk_divider_prog;
  localparam int W     = 8;
  localparam int DEF_D = 4;

  logic clk_i = 1'b0;
  logic rst   = 1'b1;
  always #5 clk_i = ~clk_i;

  clk_divider_prog_if #(.DIV_WIDTH(W)) bus ();

  clk_divider_prog #(.DIV_WIDTH(W), .DEFAULT_DIV(DEF_D)) dut (
    .clk_i (clk_i),
    .rst   (rst),
    .bus   (bus)
  );

  typedef struct {
    int clk;
    int ack;
    int cur;
    int tick;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  int ack_seen = 0;

  // Reference model: mode 0 idle, 1 running, 2 finishing the period before parking.
  int m_mode = 0;
  int m_d    = DEF_D;
  int m_ph   = DEF_D - 1;
  int m_pv   = 0;
  int m_pend = 0;
  int m_clk  = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  task automatic model(input bit r, input bit e, input int dv, input bit ld, output exp_t x);
    int eff, nd, prev;
    bit eff_v, last, ack;
    prev = m_clk;
    if (r) begin
      m_mode = 0; m_d = DEF_D; m_ph = DEF_D - 1; m_pv = 0; m_clk = 0;
      x.clk = 0; x.ack = 0; x.cur = DEF_D; x.tick = 0;
      return;
    end
    eff_v = ld || (m_pv != 0);
    eff   = ld ? ((dv < 2) ? 2 : dv) : m_pend;
    last  = (m_ph == m_d - 1);
    ack   = last && eff_v;
    nd    = ack ? eff : m_d;
    if (ld) m_pend = (dv < 2) ? 2 : dv;
    m_pv = (eff_v && !ack) ? 1 : 0;
    if (m_mode == 0 || last) begin
      if (e) begin m_mode = 1; m_ph = 0; end
      else   begin m_mode = 0; m_ph = nd - 1; end
    end else begin
      m_ph   = m_ph + 1;
      m_mode = e ? 1 : 2;
    end
    m_d   = nd;
    m_clk = (m_ph < m_d / 2) ? 1 : 0;
    x.clk = m_clk; x.ack = ack; x.cur = m_d;
    x.tick = (m_clk == 1 && prev == 0) ? 1 : 0;
  endtask

  task automatic step(input bit r, input bit e, input int dv, input bit ld);
    exp_t x;
    rst            = r;
    bus.en_i       = e;
    bus.div_i      = W'(dv);
    bus.div_load_i = ld;
    model(r, e, dv, ld, x);
    sb.push_back(x);
    @(negedge clk_i);
  endtask

  task automatic run(input bit e, input int n);
    for (int i = 0; i < n; i++) step(1'b0, e, 0, 1'b0);
  endtask

  // Monitor: one prediction per clock, compared just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk_i);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        if (bus.div_ack_o) ack_seen++;
        chk("clk_o", int'(bus.clk_o), x.clk);
        chk("div_ack_o", int'(bus.div_ack_o), x.ack);
        chk("cur_div_o", int'(bus.cur_div_o), x.cur);
`ifdef CLK_DIV_PROG_TICK_EN
        chk("tick_o", int'(bus.tick_o), x.tick);
`endif
      end
    end
  end

  initial begin
    int guard;
    bus.en_i = 1'b0; bus.div_i = '0; bus.div_load_i = 1'b0;
    @(negedge clk_i);

    // Reset then free-run at the default divisor.
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    ack_seen = 0;
    run(1'b1, 12);
    chk("no_ack_default", ack_seen, 0);
    chk("cur_div_default", int'(bus.cur_div_o), 4);

    // Load 5 mid-period.
    guard = 0;
    while (m_ph != 1 && guard < 20) begin run(1'b1, 1); guard++; end
    chk("sync_ph1_a", m_ph, 1);
    step(1'b0, 1'b1, 5, 1'b1);
    run(1'b1, 15);
    chk("cur_div_5", int'(bus.cur_div_o), 5);

    // Clamp: 0 and 1 both become 2.
    step(1'b0, 1'b1, 0, 1'b1);
    run(1'b1, 6);
    step(1'b0, 1'b1, 1, 1'b1);
    run(1'b1, 10);
    chk("cur_div_clamp", int'(bus.cur_div_o), 2);

    // D=6, drop en_i while high, then restart.
    step(1'b0, 1'b1, 6, 1'b1);
    guard = 0;
    while (!(m_d == 6 && m_ph == 1) && guard < 30) begin run(1'b1, 1); guard++; end
    chk("sync_ph1_b", m_ph, 1);
    run(1'b0, 10);
    chk("parked_low", int'(bus.clk_o), 0);
    run(1'b1, 12);

    // Back-to-back loads: only the latest is applied, with one ack.
    guard = 0;
    while (m_ph != 0 && guard < 30) begin run(1'b1, 1); guard++; end
    ack_seen = 0;
    step(1'b0, 1'b1, 8, 1'b1);
    step(1'b0, 1'b1, 10, 1'b1);
    run(1'b1, 20);
    chk("single_ack", ack_seen, 1);
    chk("cur_div_10", int'(bus.cur_div_o), 10);

    // Reset while clk_o high with a load pending.
    guard = 0;
    while (m_clk != 1 && guard < 30) begin run(1'b1, 1); guard++; end
    step(1'b0, 1'b1, 3, 1'b1);
    step(1'b1, 1'b1, 0, 1'b0);
    chk("rst_clk_low", int'(bus.clk_o), 0);
    chk("rst_cur_div", int'(bus.cur_div_o), DEF_D);
    ack_seen = 0;
    run(1'b1, 12);
    chk("rst_drops_pending", ack_seen, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, e, ld;
      int dv;
      r  = ($urandom_range(0, 199) == 0);
      e  = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 11) == 0);
      dv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
      step(r, e, dv, ld);
    end

    @(negedge clk_i);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
